p18_paddle_controller: RTL and testbench

P18_PADDLE_CONTROLLER -- requirements
Module: p18_paddle_controller

---
 rtl/p18_pkg.sv | 18 +
 rtl/p18_sync2.sv | 27 ++
 rtl/p18_paddle_controller.sv | 110 +++++++++++
 tb/tb_p18_paddle_controller.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/p18_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | p18_pkg: shared screen geometry, tick line and paddle FSM encoding.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package p18_pkg;
    localparam int         SCREEN_WIDTH = 640;
    localparam int         PADDLE_WIDTH = 48;
    localparam logic [8:0] TICK_LINE    = 9'd480;
    localparam int         X_MAX        = SCREEN_WIDTH - PADDLE_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVE_L = 2'd1,
        ST_MOVE_R = 2'd2
    } state_t;
endpackage
`default_nettype wire

// File: rtl/p18_sync2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | p18_sync2: two-flop synchronizer for one asynchronous input.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module p18_sync2 (
    input  logic clk,
    input  logic nRst,
    input  logic d,
    output logic q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;
endmodule
`default_nettype wire

// File: rtl/p18_paddle_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | p18_paddle_controller: button-driven paddle x with per-frame motion, |
// | acceleration and wall clamping. Rev 1.0                              |
// +----------------------------------------------------------------------+
module p18_paddle_controller
    import p18_pkg::*;
#(
    parameter int         SCREEN_WIDTH = p18_pkg::SCREEN_WIDTH,
    parameter int         PADDLE_WIDTH = p18_pkg::PADDLE_WIDTH,
    parameter int         X_RESET      = 296,
    parameter int         SPEED_MIN    = 1,
    parameter int         SPEED_MAX    = 8,
    parameter int         ACCEL_FRAMES = 4,
    parameter logic [8:0] TICK_LINE    = p18_pkg::TICK_LINE
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic [9:0] hpos,
    input  logic [8:0] vpos,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       enable,
    output logic [9:0] x,
    output logic [3:0] speed,
    output logic       at_wall,
    output logic       frame_tick
);
    localparam logic [10:0] C_X_MAX      = 11'(SCREEN_WIDTH - PADDLE_WIDTH);
    localparam logic [9:0]  C_X_RESET    = 10'(X_RESET);
    localparam logic [3:0]  C_SPEED_MIN  = 4'(SPEED_MIN);
    localparam logic [3:0]  C_SPEED_MAX  = 4'(SPEED_MAX);
    localparam logic [7:0]  C_ACCEL_LAST = 8'(ACCEL_FRAMES - 1);

    logic [1:0]  r_rst_sync;
    logic        w_rst_n;
    logic        w_left;
    logic        w_right;
    state_t      r_state, w_state_n;
    logic [9:0]  r_x, w_x_n;
    logic [3:0]  r_speed, w_speed_n;
    logic [7:0]  r_cnt, w_cnt_n;
    logic        r_tick;
    logic [10:0] w_x11, w_step11, w_diff, w_sum;

    // Assertion is immediate; release is retimed to clk so no flop sees a partial edge.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) r_rst_sync <= 2'b00;
        else       r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    p18_sync2 u_sync_left  (.clk(clk), .nRst(w_rst_n), .d(btn_left),  .q(w_left));
    p18_sync2 u_sync_right (.clk(clk), .nRst(w_rst_n), .d(btn_right), .q(w_right));

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= ST_IDLE;
            r_x     <= C_X_RESET;
            r_speed <= C_SPEED_MIN;
            r_cnt   <= 8'd0;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_x     <= w_x_n;
            r_speed <= w_speed_n;
            r_cnt   <= w_cnt_n;
            r_tick  <= (hpos == 10'd0) && (vpos == TICK_LINE);
        end
    end

    assign w_x11    = {1'b0, r_x};
    assign w_step11 = {7'd0, w_speed_n};
    assign w_diff   = w_x11 - w_step11;
    assign w_sum    = w_x11 + w_step11;

    always_comb begin
        w_state_n = r_state;
        w_x_n     = r_x;
        w_speed_n = r_speed;
        w_cnt_n   = r_cnt;
        if (r_tick) begin
            if (!enable || (w_left == w_right)) begin
                w_state_n = ST_IDLE;
                w_speed_n = C_SPEED_MIN;
                w_cnt_n   = 8'd0;
            end else begin
                w_state_n = w_left ? ST_MOVE_L : ST_MOVE_R;
                if (r_state != w_state_n) begin
                    w_speed_n = C_SPEED_MIN;
                    w_cnt_n   = 8'd0;
                end else if (r_cnt == C_ACCEL_LAST) begin
                    // The frame that completes an acceleration period already moves at the new speed.
                    w_cnt_n = 8'd0;
                    if (r_speed < C_SPEED_MAX) w_speed_n = r_speed + 4'd1;
                end else begin
                    w_cnt_n = r_cnt + 8'd1;
                end
                if (w_left) w_x_n = (w_x11 < w_step11) ? 10'd0 : w_diff[9:0];
                else        w_x_n = (w_sum > C_X_MAX) ? C_X_MAX[9:0] : w_sum[9:0];
            end
        end
    end

    assign x          = r_x;
    assign speed      = r_speed;
    assign frame_tick = r_tick;
    assign at_wall    = (r_x == 10'd0) || (w_x11 == C_X_MAX);
endmodule
`default_nettype wire

// File: tb/tb_p18_paddle_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_p18_paddle_controller: directed stimulus with a per-tick         |
// | scoreboard of expected x/speed/at_wall. Rev 1.0                      |
// +----------------------------------------------------------------------+
module tb_p18_paddle_controller;
    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic [9:0] hpos = 10'd5;
    logic [8:0] vpos = 9'd0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       enable = 1'b1;
    logic [9:0] x;
    logic [3:0] speed;
    logic       at_wall;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;

    typedef struct {int x; int sp; int wall; string tag;} exp_t;
    exp_t sb[$];

    int m_x, m_sp, m_cnt, m_st;  // m_st: 0 idle, 1 left, 2 right

    p18_paddle_controller dut (
        .clk(clk), .nRst(nRst), .hpos(hpos), .vpos(vpos),
        .btn_left(btn_left), .btn_right(btn_right), .enable(enable),
        .x(x), .speed(speed), .at_wall(at_wall), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_x = 296; m_sp = 1; m_cnt = 0; m_st = 0;
    endtask

    task automatic model_step(input bit l, input bit r, input bit en);
        int dir;
        if (!en || (l == r)) begin
            m_st = 0; m_sp = 1; m_cnt = 0;
        end else begin
            dir = l ? 1 : 2;
            if (m_st != dir) begin
                m_st = dir; m_sp = 1; m_cnt = 0;
            end else begin
                m_cnt++;
                if (m_cnt == 4) begin
                    m_cnt = 0;
                    if (m_sp < 8) m_sp++;
                end
            end
            if (dir == 1) m_x = (m_x < m_sp) ? 0 : m_x - m_sp;
            else          m_x = (m_x + m_sp > 592) ? 592 : m_x + m_sp;
        end
    endtask

    task automatic do_tick(input string tag);
        exp_t e;
        repeat (3) @(posedge clk);
        model_step(btn_left, btn_right, enable);
        e.x = m_x; e.sp = m_sp; e.wall = (m_x == 0 || m_x == 592) ? 1 : 0; e.tag = tag;
        sb.push_back(e);
        @(negedge clk); hpos = 10'd0; vpos = 9'd480;
        @(negedge clk); hpos = 10'd5; vpos = 9'd0;
        check({tag, "_tick_hi"}, 32'(frame_tick), 32'd1);
        @(negedge clk);
        check({tag, "_tick_lo"}, 32'(frame_tick), 32'd0);
        e = sb.pop_front();
        check({e.tag, "_x"},     32'(x),       e.x);
        check({e.tag, "_speed"}, 32'(speed),   e.sp);
        check({e.tag, "_wall"},  32'(at_wall), e.wall);
    endtask

    initial begin
        model_reset();
        #12;
        check("rst_x", 32'(x), 32'd296);
        check("rst_speed", 32'(speed), 32'd1);
        check("rst_tick", 32'(frame_tick), 32'd0);
        check("rst_wall", 32'(at_wall), 32'd0);
        @(negedge clk); nRst = 1'b1;
        repeat (4) @(negedge clk);

        // Right held: 297,298,299,300,302,304 then on to the right wall.
        btn_right = 1'b1;
        for (int i = 0; i < 60; i++) do_tick("right");
        check("right_wall_x", 32'(x), 32'd592);

        // Reversal mid-acceleration, then left to the left wall.
        btn_right = 1'b0; btn_left = 1'b1;
        for (int i = 0; i < 100; i++) do_tick("left");
        check("left_wall_x", 32'(x), 32'd0);

        // Out of the wall, then both pressed and disabled with right held.
        btn_left = 1'b0; btn_right = 1'b1;
        for (int i = 0; i < 6; i++) do_tick("right2");
        btn_left = 1'b1;
        for (int i = 0; i < 3; i++) do_tick("both");
        btn_left = 1'b0; enable = 1'b0;
        for (int i = 0; i < 3; i++) do_tick("disabled");
        enable = 1'b1;
        for (int i = 0; i < 7; i++) do_tick("right3");

        // Reset while frame_tick is high and the paddle is moving.
        repeat (3) @(posedge clk);
        @(negedge clk); hpos = 10'd0; vpos = 9'd480;
        @(negedge clk); hpos = 10'd5; vpos = 9'd0;
        #1 nRst = 1'b0;
        #1;
        model_reset();
        check("midrst_x", 32'(x), 32'(m_x));
        check("midrst_speed", 32'(speed), 32'(m_sp));
        check("midrst_tick", 32'(frame_tick), 32'd0);
        btn_right = 1'b0;
        @(negedge clk); nRst = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_x", 32'(x), 32'd296);

        // Single-cycle button pulse between ticks must not move the paddle.
        @(negedge clk); btn_right = 1'b1;
        @(negedge clk); btn_right = 1'b0;
        repeat (4) @(negedge clk);
        do_tick("pulse");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
